// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// Module : calc_pkg
// Brief  : Shared op codes and FSM state encoding for the calculator datapath.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_CPL1 = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_if.sv
//------------------------------------------------------------------------------
// Module : serial_addsub_if
// Brief  : start/busy/done handshake and operand/result bus for serial_addsub.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

`default_nettype wire

// File: rtl/addsub_chunk.sv
//------------------------------------------------------------------------------
// Module : addsub_chunk
// Brief  : Combinational BITS-wide ripple of full-adder cells.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub_chunk #(
    parameter int BITS = 1
) (
    input  wire logic [BITS-1:0] i_a,
    input  wire logic [BITS-1:0] i_b,
    input  wire logic            i_cin,
    output logic      [BITS-1:0] o_sum,
    output logic                 o_cout,
    output logic                 o_cmsb
);

    logic [BITS:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < BITS; i++) begin : g_bit
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[BITS];
    // Carry into the top bit; combined with o_cout it yields signed overflow.
    assign o_cmsb = w_c[BITS-1];

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
//------------------------------------------------------------------------------
// Module : serial_addsub
// Brief  : Multi-cycle LSB-first add/sub/ones'-complement unit, BITS_PER_CYCLE per clock.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_addsub
    import calc_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_addsub_if.slave     bus
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

    if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_param_check
        $error("serial_addsub: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end

    logic [1:0]                r_state;
    logic [WIDTH-1:0]          r_opa;
    logic [WIDTH-1:0]          r_opb;
    logic [WIDTH-1:0]          r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_carry;
    logic                      r_cpl;
    logic [WIDTH-1:0]          r_result;
    logic                      r_carry_out;
    logic                      r_overflow;

    logic [BITS_PER_CYCLE-1:0] w_sum;
    logic [BITS_PER_CYCLE-1:0] w_chunk;
    logic                      w_cout;
    logic                      w_cmsb;
    logic [WIDTH-1:0]          w_chunk_ext;
    logic [WIDTH-1:0]          w_acc_next;
    logic                      w_last;

    addsub_chunk #(
        .BITS (BITS_PER_CYCLE)
    ) u_chunk (
        .i_a    (r_opa[BITS_PER_CYCLE-1:0]),
        .i_b    (r_opb[BITS_PER_CYCLE-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    // Ones' complement bypasses the adder so no carry ripples within a chunk.
    assign w_chunk     = r_cpl ? (r_opa[BITS_PER_CYCLE-1:0] ^ r_opb[BITS_PER_CYCLE-1:0]) : w_sum;
    assign w_chunk_ext = WIDTH'(w_chunk);
    assign w_acc_next  = (r_acc >> BITS_PER_CYCLE) | (w_chunk_ext << (WIDTH - BITS_PER_CYCLE));
    assign w_last      = (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cpl       <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_opa   <= bus.a;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_cpl   <= (bus.op == OP_CPL1);
                        r_carry <= (bus.op == OP_SUB);
                        case (bus.op)
                            OP_SUB:  r_opb <= ~bus.b;
                            OP_CPL1: r_opb <= '1;
                            default: r_opb <= bus.b;
                        endcase
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_opa   <= r_opa >> BITS_PER_CYCLE;
                    r_opb   <= r_opb >> BITS_PER_CYCLE;
                    r_carry <= r_cpl ? 1'b0 : w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result    <= w_acc_next;
                        r_carry_out <= r_cpl ? 1'b0 : w_cout;
                        r_overflow  <= r_cpl ? 1'b0 : (w_cout ^ w_cmsb);
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
//------------------------------------------------------------------------------
// Module : tb_serial_addsub
// Brief  : Self-checking bench for serial_addsub at BPC=1 and BPC=4, WIDTH=16.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(16)) bus1 ();
    serial_addsub_if #(.WIDTH(16)) bus4 ();

    serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          sel;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        v;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 17-bit sums and sign rules.
    function automatic logic [17:0] ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic        v;
        if (op == 2'b10) return {1'b0, 1'b0, ~a};
        if (op == 2'b01) begin
            s = {1'b0, a} - {1'b0, b} + 17'h10000;
            v = (a[15] != b[15]) && (s[15] != a[15]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            v = (a[15] == b[15]) && (s[15] != a[15]);
        end
        return {s[16], v, s[15:0]};
    endfunction

    task automatic drive(input int sel, input logic s, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        if (sel == 1) begin
            bus1.start = s; bus1.op = op; bus1.a = a; bus1.b = b;
        end else begin
            bus4.start = s; bus4.op = op; bus4.a = a; bus4.b = b;
        end
    endtask

    // {busy, done, carry_out, overflow, result}
    function automatic logic [19:0] outs(input int sel);
        if (sel == 1) return {bus1.busy, bus1.done, bus1.carry_out, bus1.overflow, bus1.result};
        return {bus4.busy, bus4.done, bus4.carry_out, bus4.overflow, bus4.result};
    endfunction

    task automatic run_op(input int sel, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic c, output logic v,
                          output int lat, output int busyc);
        logic [19:0] o;
        @(negedge clk);
        drive(sel, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(sel, 1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        lat = -1; busyc = 0;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            o = outs(sel);
            if (o[19]) busyc++;
            if (o[18]) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        o = outs(sel);
        r = o[15:0]; c = o[17]; v = o[16];
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] r;
        logic        c, v;
        logic [17:0] m;
        int          lat, busyc, n;
        logic [19:0] o;
        int          dcount, last_done;
        logic        saw_done;

        tbl[0] = '{1, 2'b00, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
        tbl[1] = '{1, 2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        tbl[2] = '{1, 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        tbl[3] = '{1, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{1, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[5] = '{1, 2'b10, 16'h00F0, 16'hAAAA, 16'hFF0F, 1'b0, 1'b0};
        tbl[6] = '{1, 2'b11, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0};
        tbl[7] = '{4, 2'b00, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 1'b0};
        tbl[8] = '{4, 2'b10, 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 1'b0};
        tbl[9] = '{4, 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};

        drive(1, 1'b0, 2'b00, 16'h0, 16'h0);
        drive(4, 1'b0, 2'b00, 16'h0, 16'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut1", 32'(outs(1)), 32'h0);
        chk("reset_dut4", 32'(outs(4)), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            n = (tbl[i].sel == 1) ? 16 : 4;
            run_op(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, r, c, v, lat, busyc);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(tbl[i].res));
            chk($sformatf("vec%0d_cv", i), {30'd0, c, v}, {30'd0, tbl[i].c, tbl[i].v});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(n));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(busyc), 32'(n));
        end

        for (int k = 0; k < 40; k++) begin
            logic [1:0]  op;
            logic [15:0] a, b;
            int          sel;
            sel = (k % 2 == 0) ? 1 : 4;
            op  = 2'($urandom_range(0, 3));
            a   = 16'($urandom);
            b   = 16'($urandom);
            if (k % 8 == 1) a = 16'h8000;
            if (k % 8 == 3) b = 16'hFFFF;
            m = ref_model(op, a, b);
            run_op(sel, op, a, b, r, c, v, lat, busyc);
            chk($sformatf("rand%0d_op%0d_%h_%h", k, op, a, b), {13'd0, c, v, r}, {13'd0, m});
            chk($sformatf("rand%0d_latency", k), 32'(lat), 32'((sel == 1) ? 16 : 4));
        end

        // A start pulse during RUN must not disturb the operation in flight.
        @(negedge clk);
        drive(1, 1'b1, 2'b00, 16'h1234, 16'h0FCD);
        @(posedge clk); #1;
        drive(1, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (5) begin @(posedge clk); #1; end
        drive(1, 1'b1, 2'b01, 16'h5555, 16'h0001);
        @(posedge clk); #1;
        drive(1, 1'b0, 2'b00, 16'h0, 16'h0);
        saw_done = 1'b0;
        for (int cyc = 0; cyc < 30 && !saw_done; cyc++) begin
            if (bus1.done) saw_done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("ignore_start_done_seen", 32'(saw_done), 32'd1);
        chk("ignore_start_result", 32'(bus1.result), 32'h2201);
        @(posedge clk); #1;
        chk("ignore_start_idle1", {30'd0, bus1.busy, bus1.done}, 32'd0);
        @(posedge clk); #1;
        chk("ignore_start_idle2", {30'd0, bus1.busy, bus1.done}, 32'd0);

        // Asynchronous reset mid-RUN clears everything and drops the op.
        @(negedge clk);
        drive(1, 1'b1, 2'b00, 16'hFFFF, 16'h0001);
        @(posedge clk); #1;
        drive(1, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (8) begin @(posedge clk); #1; end
        chk("pre_reset_busy", 32'(bus1.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(outs(1)), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (bus1.done || bus1.busy) dcount++;
        end
        chk("no_done_after_reset", 32'(dcount), 32'd0);
        run_op(1, 2'b01, 16'h8000, 16'h0001, r, c, v, lat, busyc);
        chk("post_reset_op", {13'd0, c, v, r}, {13'd0, 1'b1, 1'b1, 16'h7FFF});
        chk("post_reset_latency", 32'(lat), 32'd16);

        // Start held high on the BPC=4 unit: done every N+2 = 6 cycles.
        @(negedge clk);
        drive(4, 1'b1, 2'b00, 16'hABCD, 16'h1111);
        dcount = 0; last_done = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            o = outs(4);
            if (o[18]) begin
                if (dcount == 0) chk("b2b_first_done", 32'(cyc), 32'd4);
                else chk($sformatf("b2b_period%0d", dcount), 32'(cyc - last_done), 32'd6);
                chk($sformatf("b2b_result%0d", dcount), 32'(o[15:0]), 32'hBCDE);
                last_done = cyc;
                dcount++;
            end
        end
        chk("b2b_done_count", 32'(dcount), 32'd5);
        drive(4, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (10) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Multi-cycle, parametrised adder/subtractor/complementer for the calculator datapath. It processes operands LSB-first in chunks of BITS_PER_CYCLE bits per clock, reusing one chunk-wide ripple adder. It uses a start/busy/done handshake so the display/button control FSM can launch an operation and wait for the result. It replaces single-bit combinational full-adder usage with a complete WIDTH-bit arithmetic unit that reports carry and signed overflow.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
BITS_PER_CYCLE, 1, bits processed per RUN cycle; must divide WIDTH exactly (elaboration error otherwise)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  launch request; sampled only in IDLE
op  in  2  00 ADD a+b; 01 SUB a-b (two's complement); 10 CPL1 ~a (ones' complement, b ignored); 11 reserved, executes as ADD
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B, captured on accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; result fields valid
result  out  WIDTH  result, held until next done
carry_out  out  1  carry out of MSB (SUB: 1 = no borrow); 0 for CPL1
overflow  out  1  signed overflow (carry into MSB xor carry out of MSB); 0 for CPL1

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; internal shift registers, chunk counter and carry cleared. Reset mid-RUN aborts with no done.
- FSM states: IDLE, RUN, DONE.
- IDLE: on a clock edge with start=1:
  - latch a into opA
  - opB = b for ADD; ~b for SUB; all-ones for CPL1
  - carry = 1 for SUB, else 0
  - CPL1 computes opA XOR all-ones, with carry forced 0 and not propagated
  - count=0; go to RUN
- RUN: each edge consumes the low BITS_PER_CYCLE bits of opA/opB through the chunk adder:
  - shift the sum into the top of the accumulating result register
  - shift opA/opB right by BITS_PER_CYCLE
  - update carry; on the final chunk, record the carry into the MSB
  - count++
  - when count reaches N-1 (N = WIDTH/BITS_PER_CYCLE), the edge that processes the last chunk moves to DONE
- DONE: done=1 and busy=0 for exactly one cycle; result/carry_out/overflow are registered on entry to DONE. Next edge goes to IDLE.
- Latency: start sampled at edge k, busy=1 on cycles after edges k..k+N-1, done=1 on the cycle after edge k+N. Worked values: N=16 for WIDTH=16/BPC=1; N=4 for BPC=4.
- Result, carry_out and overflow change only on entry to DONE or on reset; they hold between operations.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new operation is accepted in each IDLE cycle. Back-to-back period is N+2 cycles.
- Operand inputs a, b, op are don't-care except on the accepting edge.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package calc_pkg:
  - op encoding localparams: OP_ADD=2'b00, OP_SUB=2'b01, OP_CPL1=2'b10
  - FSM state encoding: IDLE/RUN/DONE
- One sub-module is natural: addsub_chunk, a combinational BITS_PER_CYCLE-wide ripple of single-bit full-adder cells. It exposes sum, carry-out, and carry into its top bit (for overflow on the final chunk).
- The FSM, counter and shift registers stay in serial_addsub.

Test Plan:
1. WIDTH=16, BPC=1, ADD a=0x1234 b=0x0FCD -> result=0x2201, carry_out=0, overflow=0; done high exactly on the cycle after edge k+16; busy high for 16 cycles.
2. SUB a=0x0005 b=0x0007 -> result=0xFFFE, carry_out=0, overflow=0. Then SUB a=0x8000 b=0x0001 -> result=0x7FFF, carry_out=1, overflow=1.
3. ADD 0x7FFF+0x0001 -> 0x8000, carry_out=0, overflow=1. ADD 0xFFFF+0x0001 -> 0x0000, carry_out=1, overflow=0.
4. CPL1 a=0x00F0 b=0xAAAA -> result=0xFF0F, carry_out=0, overflow=0, same latency as ADD.
5. Handshake and reset:
   - Pulse start with a new operand at RUN cycle 5 -> ignored; first result unchanged.
   - Assert rst at RUN cycle 8 -> all outputs 0 immediately (async), no done pulse.
   - Next start runs normally.
6. WIDTH=16, BPC=4: ADD 0xABCD+0x1111 -> 0xBCDE, done on the cycle after edge k+4. With start held high, done pulses repeat every 6 cycles.
